// File: rtl/ecc_pkg.sv
// ecc_pkg: shared ECC helpers for the SRAM bank blocks.
//   get_cw_width(data_width): SECDED codeword width, i.e. data bits plus the
//   Hamming parity bits needed to cover them plus one overall parity bit.
package ecc_pkg;

    function automatic int unsigned get_cw_width(input int unsigned data_width);
        int unsigned p;
        logic        found;
        p     = 0;
        found = 1'b0;
        // Smallest p with 2^p >= data + p + 1.
        for (int unsigned i = 1; i < 32; i++) begin
            if (!found && ((32'd1 << i) >= (data_width + i + 1))) begin
                p     = i;
                found = 1'b1;
            end
        end
        return data_width + p + 1;
    endfunction

endpackage

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber for one ECC-protected SRAM bank.
// Walks the bank one codeword per step, hands each read word to an external
// SECDED decoder and writes the corrected word back on a single-bit error.
// The external requester always wins the bank.
//   clk_i, rst_i (async, active-high)
//   scrub_trigger_i      : starts one scrub step when idle (pulse or level)
//   intc_*               : external requester port, passed straight to the bank
//   bank_*               : bank port (external traffic or scrub traffic)
//   ecc_out_o            : read codeword to the decoder
//   ecc_in_i, ecc_err_i  : decoder result ([0] corrected, [1] uncorrectable)
//   bit_corrected_o      : 1-cycle pulse per issued write-back
//   uncorrectable_o      : 1-cycle pulse per double error found
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int unsigned BankSize  = 256,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CwWidth   = ecc_pkg::get_cw_width(DataWidth),
    parameter int unsigned AddrWidth = $clog2(BankSize)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 scrub_trigger_i,
    input  logic                 intc_req_i,
    input  logic                 intc_we_i,
    input  logic [AddrWidth-1:0] intc_add_i,
    input  logic [CwWidth-1:0]   intc_wdata_i,
    output logic [CwWidth-1:0]   intc_rdata_o,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_add_o,
    output logic [CwWidth-1:0]   bank_wdata_o,
    input  logic [CwWidth-1:0]   bank_rdata_i,
    output logic [CwWidth-1:0]   ecc_out_o,
    input  logic [CwWidth-1:0]   ecc_in_i,
    input  logic [1:0]           ecc_err_i,
    output logic                 bit_corrected_o,
    output logic                 uncorrectable_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } scrub_state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(BankSize - 1);

    scrub_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [CwWidth-1:0]   wdata_q, wdata_d;
    logic                 corr_q, corr_d;
    logic                 unc_q, unc_d;

    logic                 scrub_req;
    logic                 scrub_we;
    logic [AddrWidth-1:0] addr_next;
    logic                 stale_wr;

    assign addr_next = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);

    // External write hitting the word we are about to write back makes our
    // corrected copy stale.
    assign stale_wr = intc_req_i && intc_we_i && (intc_add_i == addr_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        corr_d    = 1'b0;
        unc_d     = 1'b0;
        scrub_req = 1'b0;
        scrub_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scrub_trigger_i) begin
                    state_d = READ;
                end
            end
            READ: begin
                scrub_req = 1'b1;
                if (!intc_req_i) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (ecc_err_i[1]) begin
                    unc_d   = 1'b1;
                    addr_d  = addr_next;
                    state_d = IDLE;
                end else if (ecc_err_i[0]) begin
                    wdata_d = ecc_in_i;
                    state_d = WRITE;
                end else begin
                    addr_d  = addr_next;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                scrub_req = 1'b1;
                scrub_we  = 1'b1;
                if (stale_wr) begin
                    addr_d  = addr_next;
                    state_d = IDLE;
                end else if (!intc_req_i) begin
                    corr_d  = 1'b1;
                    addr_d  = addr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            corr_q  <= corr_d;
            unc_q   <= unc_d;
        end
    end

    always_comb begin
        if (intc_req_i) begin
            bank_req_o   = 1'b1;
            bank_we_o    = intc_we_i;
            bank_add_o   = intc_add_i;
            bank_wdata_o = intc_wdata_i;
        end else begin
            bank_req_o   = scrub_req;
            bank_we_o    = scrub_we;
            bank_add_o   = addr_q;
            bank_wdata_o = wdata_q;
        end
    end

    assign intc_rdata_o    = bank_rdata_i;
    assign ecc_out_o       = bank_rdata_i;
    assign bit_corrected_o = corr_q;
    assign uncorrectable_o = unc_q;

endmodule
